reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, shall set the register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, shall set the address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  shall be the single clock; all register updates occur on its rising edge.
REQ-004 reset  input  1  shall be the asynchronous, active-high reset.
REQ-005 we  input  1  shall be the write enable, sampled at the rising edge of clk.
REQ-006 wa  input  ADDR_W  shall be the write address.
REQ-007 wd  input  DATA_W  shall be the write data.
REQ-008 ra1  input  ADDR_W  shall be the read address for port 1 (rs).
REQ-009 ra2  input  ADDR_W  shall be the read address for port 2 (rt).
REQ-010 rd1  output  DATA_W  shall be the read data for port 1.
REQ-011 rd2  output  DATA_W  shall be the read data for port 2.

Function
REQ-012 The block shall hold 32 registers of DATA_W bits each, r0..r31.
REQ-013 On a rising clk edge with we=1, wa!=0 and reset=0, register r[wa] shall load wd.
REQ-014 A write with wa=0 shall be discarded; r0 shall read 0 at all times.
REQ-015 A write with we=0 shall leave every register unchanged.
REQ-016 Reads shall be combinational with zero-cycle latency: rd1=r[ra1], rd2=r[ra2], via one 32-to-1 selection per port.
REQ-017 ra1 and ra2 may be equal, or may equal wa; both ports shall then return the same value, independently of each other.
REQ-018 Without bypass, a read of the register being written in the same cycle shall return the old value until after the clk edge, then the new value.
REQ-019 The block shall contain no other state: no pending-write queue, and no handshake beyond we.

Reset
REQ-020 While reset=1, all 32 registers shall clear to 0 immediately, independent of clk.
REQ-021 While reset=1, rd1 and rd2 shall read 0 for every address, except the same-cycle bypass path when REGFILE_BYPASS_EN is defined (REQ-026).
REQ-022 A write coinciding with a reset assertion shall be lost; reset has priority.
REQ-023 After reset deasserts, the first write shall take effect at the first rising clk edge with we=1.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN shall control write-to-read forwarding.
REQ-025 When REGFILE_BYPASS_EN is defined and we=1, wa!=0 and ra==wa, that port shall return wd combinationally in the same cycle.
REQ-026 This same-cycle bypass shall apply even while reset=1; the registers still do not update.
REQ-027 When REGFILE_BYPASS_EN is not defined, reads shall return stored register contents only (REQ-018).
REQ-028 With or without REGFILE_BYPASS_EN, a write to wa=0 shall never forward; r0 reads 0.

Structure
REQ-029 Shared package constants shall be: DATA_W=32, ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0.
REQ-030 Each storage element shall be one instance of sub-module reg_32bit (clk, reset, en, d, q) with asynchronous clear.
REQ-031 Read selection shall reuse the existing mux_32to1 (select s, inputs i0..i31, output z), one instance per read port; no new mux module shall be written.

Verification
REQ-032 Reset: pulse reset mid-cycle, then read ra1=0..31 -> rd1=0 for all; the clear happens without a clk edge.
REQ-033 Write/read: we=1, wa=5, wd=32'hDEADBEEF, one clk edge; then ra1=5, ra2=5 -> rd1=rd2=32'hDEADBEEF.
REQ-034 r0: we=1, wa=0, wd=32'hFFFFFFFF, clk edge; ra1=0 -> rd1=0, with and without REGFILE_BYPASS_EN.
REQ-035 Same-cycle read: r31=7, then we=1, wa=31, wd=9, ra1=31 before the edge -> rd1=7 without bypass, 9 with bypass; after the edge -> rd1=9.
REQ-036 Dual-port independence: write r1=5 and r2=6, then ra1=2, ra2=1 -> rd1=6, rd2=5; r3 is untouched and reads 0.
REQ-037 Reset vs write: r4=3, then reset=1 with we=1, wa=4, wd=8 across a clk edge; after reset deasserts, ra1=4 -> rd1=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file slice.
package reg_file_pkg;
    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/mux_32to1.sv
// Existing 32-to-1 word selector shared across the codebase.
module mux_32to1 #(
    parameter int W = 32
) (
    input  logic [4:0]   s,
    input  logic [W-1:0] i0,  input logic [W-1:0] i1,  input logic [W-1:0] i2,  input logic [W-1:0] i3,
    input  logic [W-1:0] i4,  input logic [W-1:0] i5,  input logic [W-1:0] i6,  input logic [W-1:0] i7,
    input  logic [W-1:0] i8,  input logic [W-1:0] i9,  input logic [W-1:0] i10, input logic [W-1:0] i11,
    input  logic [W-1:0] i12, input logic [W-1:0] i13, input logic [W-1:0] i14, input logic [W-1:0] i15,
    input  logic [W-1:0] i16, input logic [W-1:0] i17, input logic [W-1:0] i18, input logic [W-1:0] i19,
    input  logic [W-1:0] i20, input logic [W-1:0] i21, input logic [W-1:0] i22, input logic [W-1:0] i23,
    input  logic [W-1:0] i24, input logic [W-1:0] i25, input logic [W-1:0] i26, input logic [W-1:0] i27,
    input  logic [W-1:0] i28, input logic [W-1:0] i29, input logic [W-1:0] i30, input logic [W-1:0] i31,
    output logic [W-1:0] z
);

    // Pure combinational selection of one of 32 inputs.
    always_comb begin
        z = '0;
        case (s)
            5'd0:  z = i0;   5'd1:  z = i1;   5'd2:  z = i2;   5'd3:  z = i3;
            5'd4:  z = i4;   5'd5:  z = i5;   5'd6:  z = i6;   5'd7:  z = i7;
            5'd8:  z = i8;   5'd9:  z = i9;   5'd10: z = i10;  5'd11: z = i11;
            5'd12: z = i12;  5'd13: z = i13;  5'd14: z = i14;  5'd15: z = i15;
            5'd16: z = i16;  5'd17: z = i17;  5'd18: z = i18;  5'd19: z = i19;
            5'd20: z = i20;  5'd21: z = i21;  5'd22: z = i22;  5'd23: z = i23;
            5'd24: z = i24;  5'd25: z = i25;  5'd26: z = i26;  5'd27: z = i27;
            5'd28: z = i28;  5'd29: z = i29;  5'd30: z = i30;  5'd31: z = i31;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/reg_32bit.sv
// Single storage word with load enable and asynchronous clear.
module reg_32bit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear immediately on reset; otherwise load d when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with hard-wired zero register r0.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a
// read port whose address matches the (non-zero) write address.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mux1;
    logic [DATA_W-1:0] mux2;
    logic              wr_ok;

    // r0 has no storage: it is a constant zero feeding both selectors.
    assign regs[0] = '0;
    assign wr_ok   = we && (wa != ADDR_W'(REG_ZERO));

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_reg
            logic wen;
            assign wen = wr_ok && (wa == ADDR_W'(g));
            reg_32bit #(.W(DATA_W)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (wen),
                .d     (wd),
                .q     (regs[g])
            );
        end
    endgenerate

    mux_32to1 #(.W(DATA_W)) u_mux1 (
        .s(ra1),
        .i0 (regs[0]),  .i1 (regs[1]),  .i2 (regs[2]),  .i3 (regs[3]),
        .i4 (regs[4]),  .i5 (regs[5]),  .i6 (regs[6]),  .i7 (regs[7]),
        .i8 (regs[8]),  .i9 (regs[9]),  .i10(regs[10]), .i11(regs[11]),
        .i12(regs[12]), .i13(regs[13]), .i14(regs[14]), .i15(regs[15]),
        .i16(regs[16]), .i17(regs[17]), .i18(regs[18]), .i19(regs[19]),
        .i20(regs[20]), .i21(regs[21]), .i22(regs[22]), .i23(regs[23]),
        .i24(regs[24]), .i25(regs[25]), .i26(regs[26]), .i27(regs[27]),
        .i28(regs[28]), .i29(regs[29]), .i30(regs[30]), .i31(regs[31]),
        .z(mux1)
    );

    mux_32to1 #(.W(DATA_W)) u_mux2 (
        .s(ra2),
        .i0 (regs[0]),  .i1 (regs[1]),  .i2 (regs[2]),  .i3 (regs[3]),
        .i4 (regs[4]),  .i5 (regs[5]),  .i6 (regs[6]),  .i7 (regs[7]),
        .i8 (regs[8]),  .i9 (regs[9]),  .i10(regs[10]), .i11(regs[11]),
        .i12(regs[12]), .i13(regs[13]), .i14(regs[14]), .i15(regs[15]),
        .i16(regs[16]), .i17(regs[17]), .i18(regs[18]), .i19(regs[19]),
        .i20(regs[20]), .i21(regs[21]), .i22(regs[22]), .i23(regs[23]),
        .i24(regs[24]), .i25(regs[25]), .i26(regs[26]), .i27(regs[27]),
        .i28(regs[28]), .i29(regs[29]), .i30(regs[30]), .i31(regs[31]),
        .z(mux2)
    );

    // Read ports: stored value, or in-flight write data when forwarding is built in.
    always_comb begin
        rd1 = mux1;
        rd2 = mux2;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (ra1 == wa)) rd1 = wd;
        if (wr_ok && (ra2 == wa)) rd2 = wd;
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed scoreboard bench for reg_file (bypass expectations follow REGFILE_BYPASS_EN).
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          c2;
    } exp_t;

    exp_t sbq[$];
    event sample_ev;
    int   n_vec  = 0;
    int   n_miss = 0;

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always #5 clk = ~clk;

    // Monitor: whenever outputs are presented, pop the expected entry and compare.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_empty rd1=%h rd2=%h no expectation queued", rd1, rd2);
            end else begin
                e = sbq.pop_front();
                n_vec++;
                if (rd1 !== e.e1) begin
                    n_miss++;
                    $display("FAIL %s rd1 got %h expected %h", e.name, rd1, e.e1);
                end
                if (e.c2) begin
                    n_vec++;
                    if (rd2 !== e.e2) begin
                        n_miss++;
                        $display("FAIL %s rd2 got %h expected %h", e.name, rd2, e.e2);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Queue the expectation and present the outputs for sampling.
    task automatic expect_rd(input string name, input logic [31:0] e1,
                             input logic [31:0] e2, input bit c2);
        exp_t e;
        #1;
        e.name = name; e.e1 = e1; e.e2 = e2; e.c2 = c2;
        sbq.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Asynchronous clear mid-cycle, no clock edge involved.
        write(5'd5, 32'h1234_5678);
        write(5'd17, 32'hA5A5_A5A5);
        ra1 = 5'd5; ra2 = 5'd17;
        expect_rd("pre_reset", 32'h1234_5678, 32'hA5A5_A5A5, 1'b1);
        reset = 1'b1;
        expect_rd("in_reset", 32'h0, 32'h0, 1'b1);
        reset = 1'b0;
        expect_rd("post_pulse_noedge", 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            expect_rd("reset_sweep", 32'h0, 32'h0, 1'b1);
        end

        // Basic write then dual read of the same register.
        write(5'd5, 32'hDEAD_BEEF);
        ra1 = 5'd5; ra2 = 5'd5;
        expect_rd("wr_rd_r5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

        // r0 ignores writes and never forwards.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd5;
        expect_rd("r0_same_cycle", 32'h0, 32'hDEAD_BEEF, 1'b1);
        tick();
        we = 1'b0;
        expect_rd("r0_after_edge", 32'h0, 32'hDEAD_BEEF, 1'b1);

        // we=0 leaves everything unchanged.
        we = 1'b0; wa = 5'd9; wd = 32'h5555_AAAA;
        tick();
        ra1 = 5'd9; ra2 = 5'd5;
        expect_rd("we0_noop", 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Same-cycle read of the register being written.
        write(5'd31, 32'd7);
        we = 1'b1; wa = 5'd31; wd = 32'd9; ra1 = 5'd31; ra2 = 5'd5;
        expect_rd("same_cycle_r31", BYP ? 32'd9 : 32'd7, 32'hDEAD_BEEF, 1'b1);
        tick();
        we = 1'b0;
        expect_rd("after_edge_r31", 32'd9, 32'hDEAD_BEEF, 1'b1);

        // Independent ports.
        write(5'd1, 32'd5);
        write(5'd2, 32'd6);
        ra1 = 5'd2; ra2 = 5'd1;
        expect_rd("dual_port", 32'd6, 32'd5, 1'b1);
        ra1 = 5'd3;
        expect_rd("r3_untouched", 32'h0, 32'd5, 1'b1);

        // Reset has priority over a coinciding write.
        write(5'd4, 32'd3);
        ra1 = 5'd4; ra2 = 5'd2;
        expect_rd("r4_loaded", 32'd3, 32'd6, 1'b1);
        reset = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'd8;
        expect_rd("reset_with_write", BYP ? 32'd8 : 32'd0, 32'h0, 1'b1);
        tick();
        reset = 1'b0; we = 1'b0;
        expect_rd("r4_after_reset", 32'h0, 32'h0, 1'b1);

        // First write after reset takes effect at the next edge.
        write(5'd4, 32'h0BAD_F00D);
        expect_rd("first_write_post_reset", 32'h0BAD_F00D, 32'h0, 1'b1);

        #2;
        if (sbq.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
